// File: rtl/bf_pkg.sv
// bf_pkg: shared widths, sentinel distance and state encoding for the Bellman-Ford engine.
package bf_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DEPTH = 16384;
  localparam logic [DATA_W-1:0] INF = 16'hFFFF;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] dist_t;
  typedef enum logic [1:0] {IDLE, DRAIN, INIT, RUN} state_t;
endpackage

// File: rtl/relax_pipe.sv
// relax_pipe: two-stage read-compare-conditional-write relaxation pipeline with write forwarding.
module relax_pipe
  import bf_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              acc_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] cand_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W-1:0] raddr_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              empty_o
);
  logic  s1_v_q, s2_v_q;
  addr_t s1_addr_q, s2_addr_q;
  dist_t s1_cand_q, s2_cand_q, s2_old_q;
  logic  fwd;
  assign we_o    = s2_v_q && (s2_cand_q < s2_old_q);
  assign waddr_o = s2_addr_q;
  assign wdata_o = s2_cand_q;
  assign raddr_o = s1_v_q ? s1_addr_q : '0;
  assign empty_o = !s1_v_q && !s2_v_q;
  // the SRAM read in S1 cannot yet see the write S2 commits at this same edge
  assign fwd     = we_o && (s2_addr_q == s1_addr_q);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      s1_cand_q <= '0;
      s2_v_q    <= 1'b0;
      s2_addr_q <= '0;
      s2_cand_q <= '0;
      s2_old_q  <= '0;
    end else begin
      s1_v_q    <= acc_i;
      s1_addr_q <= acc_i ? addr_i : s1_addr_q;
      s1_cand_q <= acc_i ? cand_i : s1_cand_q;
      s2_v_q    <= s1_v_q;
      s2_addr_q <= s1_addr_q;
      s2_cand_q <= s1_cand_q;
      s2_old_q  <= fwd ? s2_cand_q : rdata_i;
    end
  end
endmodule

// File: rtl/dist_relax_ctrl.sv
// dist_relax_ctrl: distance-table init sequencer, relax-pipeline front end and change tracking.
module dist_relax_ctrl
  import bf_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              init_start,
  input  logic [ADDR_W-1:0] init_src,
  output logic              init_done,
  output logic              busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_dist,
  input  logic              clr_changed,
  output logic              changed,
  output logic [15:0]       upd_count,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata
);
  state_t      state_q;
  addr_t       cnt_q, src_q, p_waddr;
  dist_t       p_wdata;
  logic        init_done_q, changed_q, p_we, p_empty, acc, init_wr, last, clr;
  logic [15:0] upd_q;
  assign req_ready  = (state_q == RUN) && !init_start;
  assign acc        = req_valid && req_ready;
  assign busy       = (state_q == DRAIN) || (state_q == INIT);
  assign init_wr    = state_q == INIT;
  assign last       = init_wr && (cnt_q == ADDR_W'(DEPTH - 1));
  assign clr        = clr_changed && (state_q != IDLE);
  assign sram_we    = init_wr || p_we;
  assign sram_waddr = init_wr ? cnt_q : p_waddr;
  assign sram_wdata = init_wr ? ((cnt_q == src_q) ? '0 : INF) : p_wdata;
  assign init_done  = init_done_q;
  assign changed    = changed_q;
  assign upd_count  = upd_q;
  relax_pipe u_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .acc_i   (acc),
    .addr_i  (req_addr),
    .cand_i  (req_dist),
    .rdata_i (sram_rdata),
    .raddr_o (sram_raddr),
    .we_o    (p_we),
    .waddr_o (p_waddr),
    .wdata_o (p_wdata),
    .empty_o (p_empty)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src_q       <= '0;
      init_done_q <= 1'b0;
      changed_q   <= 1'b0;
      upd_q       <= '0;
    end else begin
      init_done_q <= last;
      case (state_q)
        IDLE:  if (init_start) begin
          state_q <= INIT;
          src_q   <= init_src;
          cnt_q   <= '0;
        end
        RUN:   if (init_start) begin
          state_q <= DRAIN;
          src_q   <= init_src;
        end
        DRAIN: if (p_empty) begin
          state_q <= INIT;
          cnt_q   <= '0;
        end
        INIT:  begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= last ? RUN : INIT;
        end
      endcase
      // a clear coinciding with a write leaves that one write counted
      if (last || (clr && !p_we)) begin
        changed_q <= 1'b0;
        upd_q     <= '0;
      end else if (p_we) begin
        changed_q <= 1'b1;
        upd_q     <= clr ? 16'd1 : ((upd_q == 16'hFFFF) ? upd_q : upd_q + 16'd1);
      end
    end
  end
endmodule

// File: tb/tb_dist_relax_ctrl.sv
// tb_dist_relax_ctrl: directed and randomized checks of dist_relax_ctrl against a min-distance table model.
module tb_dist_relax_ctrl;
  import bf_pkg::*;
  logic        clock = 1'b0, reset_n = 1'b0, init_start = 1'b0, req_valid = 1'b0, clr_changed = 1'b0;
  logic [13:0] init_src = '0, req_addr = '0, sram_raddr, sram_waddr;
  logic [15:0] req_dist = '0, sram_rdata, sram_wdata, upd_count;
  logic        init_done, busy, req_ready, changed, sram_we;
  logic [15:0] mem [DEPTH];
  logic [15:0] exp_mem [DEPTH];
  int          exp_upd = 0, wcnt = 0, n_vec = 0, n_err = 0;
  bit          exp_ch = 1'b0, seen_a = 1'b0, seen_b = 1'b0;

  dist_relax_ctrl dut (
    .clock(clock), .reset_n(reset_n), .init_start(init_start), .init_src(init_src),
    .init_done(init_done), .busy(busy), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_dist(req_dist), .clr_changed(clr_changed), .changed(changed),
    .upd_count(upd_count), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .sram_we(sram_we),
    .sram_waddr(sram_waddr), .sram_wdata(sram_wdata)
  );

  always #5 clock = ~clock;
  assign sram_rdata = mem[sram_raddr];
  always @(posedge clock) begin
    if (sram_we) begin
      mem[sram_waddr] <= sram_wdata;
      wcnt = wcnt + 1;
      if (sram_waddr == 14'd100 && sram_wdata == 16'd7) seen_a = 1'b1;
      if (sram_waddr == 14'd101 && sram_wdata == 16'd8) seen_b = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic model_init(input int src);
    foreach (exp_mem[i]) exp_mem[i] = (i == src) ? 16'd0 : INF;
    exp_upd = 0;
    exp_ch  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20000 && !init_done; i++) tick();
    chk({tag, "_done"}, init_done, 1);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic send(input int a, input int d);
    req_valid = 1'b1;
    req_addr  = 14'(a);
    req_dist  = 16'(d);
    if (d < int'(exp_mem[a])) begin
      exp_mem[a] = 16'(d);
      exp_upd    = (exp_upd == 65535) ? exp_upd : exp_upd + 1;
      exp_ch     = 1'b1;
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic clr();
    clr_changed = 1'b1;
    tick();
    clr_changed = 1'b0;
    exp_upd = 0;
    exp_ch  = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"}, sram_we, 0);
    chk({tag, "_raddr"}, sram_raddr, 0);
    chk({tag, "_waddr"}, sram_waddr, 0);
    chk({tag, "_wdata"}, sram_wdata, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, init_done, 0);
    chk({tag, "_changed"}, changed, 0);
    chk({tag, "_upd"}, upd_count, 0);
  endtask

  initial begin
    int w0, bad, dr;
    repeat (2) tick();
    chk_reset_outs("rst");
    reset_n = 1'b1;
    tick();
    w0 = wcnt;
    init_src = 14'd5;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    model_init(5);
    wait_done("init1");
    chk("init1_writes", wcnt - w0, DEPTH);
    chk("init1_m5", mem[5], 0);
    chk("init1_m0", mem[0], INF);
    chk("init1_mlast", mem[DEPTH-1], INF);
    bad = 0;
    foreach (mem[i]) if (mem[i] !== exp_mem[i]) bad++;
    chk("init1_table", bad, 0);
    tick();
    chk("init1_pulse", init_done, 0);
    send(5, 3);
    send(7, 10);
    repeat (3) tick();
    chk("dir_m5", mem[5], exp_mem[5]);
    chk("dir_m7", mem[7], 10);
    chk("dir_changed", changed, exp_ch);
    chk("dir_upd", upd_count, exp_upd);
    clr();
    chk("clr_changed", changed, 0);
    chk("clr_upd", upd_count, 0);
    w0 = wcnt;
    send(9, 20);
    send(9, 15);
    send(9, 18);
    repeat (3) tick();
    chk("b2b_m9", mem[9], 15);
    chk("b2b_writes", wcnt - w0, 2);
    chk("b2b_upd", upd_count, exp_upd);
    clr();
    w0 = wcnt;
    send(12, 16'hFFFF);
    send(7, 10);
    repeat (3) tick();
    chk("nowr_writes", wcnt - w0, 0);
    chk("nowr_changed", changed, 0);
    chk("nowr_m12", mem[12], INF);
    send(9, 14);
    send(20, 1);
    for (int i = 0; i < 5 && !(sram_we && sram_waddr == 14'd20); i++) tick();
    clr_changed = 1'b1;
    tick();
    clr_changed = 1'b0;
    exp_upd = 1;
    exp_ch  = 1'b1;
    chk("clrwr_changed", changed, exp_ch);
    chk("clrwr_upd", upd_count, exp_upd);
    chk("clrwr_m20", mem[20], 1);
    clr();
    w0 = wcnt;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) < 7)
        send(1000 + int'($urandom_range(31)), ($urandom_range(7) == 0) ? 65535 : int'($urandom_range(2000)));
      else
        tick();
    end
    repeat (3) tick();
    bad = 0;
    for (int a = 1000; a < 1032; a++) if (mem[a] !== exp_mem[a]) bad++;
    chk("rnd_table", bad, 0);
    chk("rnd_writes", wcnt - w0, exp_upd);
    chk("rnd_upd", upd_count, exp_upd);
    chk("rnd_changed", changed, exp_ch);
    req_valid = 1'b1;
    req_addr = 14'd100;
    req_dist = 16'd7;
    tick();
    req_addr = 14'd101;
    req_dist = 16'd8;
    tick();
    req_valid = 1'b0;
    init_src = 14'd200;
    init_start = 1'b1;
    #1;
    chk("drain_ready_drop", req_ready, 0);
    tick();
    init_start = 1'b0;
    chk("drain_busy", busy, 1);
    dr = 0;
    while (dr < 10 && !(sram_we && sram_waddr == 14'd0 && sram_wdata == INF)) begin
      dr++;
      tick();
    end
    chk("drain_len", (dr >= 1 && dr <= 2), 1);
    model_init(200);
    wait_done("init2");
    chk("drain_seen100", seen_a, 1);
    chk("drain_seen101", seen_b, 1);
    chk("init2_m100", mem[100], INF);
    chk("init2_m200", mem[200], 0);
    chk("init2_m5", mem[5], INF);
    chk("init2_changed", changed, 0);
    init_src = 14'd3;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 500 && !(sram_we && sram_waddr == 14'd100); i++) tick();
    chk("mid_at100", sram_waddr, 100);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_reset_outs("mid");
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("idle_ready", req_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_we", sram_we, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
